stopwatch_counter: RTL and testbench
====================================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50_000_000, giving the clk cycles per one-second count step (minimum 2).
REQ-002 The block SHALL have the port clk, input, 1 bit: single rising-edge clock for all state.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port start, input, 1 bit: level-sensitive; 1 means run, 0 means pause.
REQ-005 The block SHALL have the port up, input, 1 bit: 1 means count up, 0 means count down; sampled on every step.
REQ-006 The block SHALL have the port clr, input, 1 bit: synchronous clear of count and prescaler.
REQ-007 The block SHALL have the port load, input, 1 bit: synchronous preset from pmin/psec.
REQ-008 The block SHALL have the ports pmin and psec, input, 8 bits each: preset values as BCD {tens, ones}.
REQ-009 The block SHALL have the ports SI0, SI1, MI0, MI1, output, 4 bits each: BCD seconds ones, seconds tens, minutes ones, minutes tens.
REQ-010 The block SHALL have the port tick, output, 1 bit: one-cycle pulse on each count step.
REQ-011 The block SHALL have the port at_limit, output, 1 bit: 1 while the count is 59:59 with up=1, or 00:00 with up=0.

Function
REQ-012 The count SHALL be held in four registered BCD digits: SI0 and MI0 range 0-9; SI1 and MI1 range 0-5.
REQ-013 A prescaler SHALL count 0..TICK_DIV-1 only in RUN state.
- At terminal count: prescaler returns to 0 and a step occurs.
- The step updates the digits and pulses tick in the same cycle.
REQ-014 The FSM SHALL have the states IDLE, RUN and HALT.
- IDLE to RUN: start=1.
- RUN to IDLE: start=0, with the prescaler held at its current value (pause keeps phase).
- RUN to HALT: see REQ-017.
- HALT to IDLE: start=0, or clr, or load.
REQ-015 An up-step SHALL increment with carry ones to tens: x9 goes to (x+1)0, and 59 seconds goes to 00 with a carry into minutes.
REQ-016 A down-step SHALL decrement with borrow: x0 goes to (x-1)9, and 00 seconds goes to 59 with a borrow from minutes.
REQ-017 The limit step SHALL behave as follows.
- Up at 59:59, or down at 00:00, follows the Configuration section.
- With saturation, the FSM goes to HALT, the digits hold, and tick is not pulsed.
REQ-018 clr SHALL have the highest synchronous priority.
- Digits go to 0, the prescaler goes to 0, the FSM goes to IDLE, and tick=0.
- clr overrides load and any step in the same cycle.
REQ-019 load (with clr=0) SHALL behave as follows.
- Digits take pmin/psec, the prescaler goes to 0, and the FSM goes to IDLE.
- The load takes precedence over a coincident step.
- Any digit field outside its range is replaced by 0 (for example psec=8'h75 loads 05).
REQ-020 A change of up while in RUN SHALL take effect on the next step with no reset of the prescaler.
REQ-021 at_limit SHALL be combinational from the registered digits and up.
REQ-022 All other outputs SHALL be registered.
REQ-023 The step-to-output latency SHALL be 0 cycles relative to tick: the digits show the new value in the cycle tick=1.

Reset
REQ-024 While reset=0, the block SHALL immediately force the following, independent of clk.
- SI0=SI1=MI0=MI1=0.
- Prescaler=0, FSM=IDLE, tick=0.
- at_limit follows from 00:00 and up.
REQ-025 A reset asserted during RUN SHALL discard the partial prescaler count.
REQ-026 After reset is released, the block SHALL begin operating on the first rising clk edge.

Configuration
REQ-027 The macro STOPWATCH_WRAP_EN SHALL select the limit behaviour.
- Defined: an up-step at 59:59 goes to 00:00 and a down-step at 00:00 goes to 59:59, with tick pulsed and the FSM staying in RUN; HALT is unreachable.
- Undefined: the limit step saturates per REQ-017.

Verification
REQ-028 The bench SHALL cover reset from an arbitrary state: TICK_DIV=4, reset=0 mid-RUN -> all digits 0, tick=0 immediately; first tick 4 cycles after start=1.
REQ-029 The bench SHALL cover up-count carry: load 00:59, up=1, start=1 -> after one tick, MI1..SI0 = 0,1,0,0.
REQ-030 The bench SHALL cover down-count borrow: load 10:00, up=0 -> after one tick, 09:59.
REQ-031 The bench SHALL cover the limit with the macro undefined: up at 59:59 -> HALT, no tick, digits hold 59:59, at_limit=1; start=0 -> IDLE.
REQ-032 The bench SHALL cover the limit with the macro defined: up at 59:59 -> 00:00 with tick; down at 00:00 -> 59:59.
REQ-033 The bench SHALL cover simultaneous events: clr and load in the same cycle as a step -> 00:00, IDLE; load psec=8'h7A -> seconds 00.

Source files
------------

// File: rtl/stopwatch_counter_if.sv
// Control, preset and display bundle for stopwatch_counter.
// The master drives the controls and presets; the slave (the counter) drives the digits and status.
interface stopwatch_counter_if;
    logic       start;
    logic       up;
    logic       clr;
    logic       load;
    logic [7:0] pmin;
    logic [7:0] psec;
    logic [3:0] SI0;
    logic [3:0] SI1;
    logic [3:0] MI0;
    logic [3:0] MI1;
    logic       tick;
    logic       at_limit;

    modport master (
        output start, up, clr, load, pmin, psec,
        input  SI0, SI1, MI0, MI1, tick, at_limit
    );

    modport slave (
        input  start, up, clr, load, pmin, psec,
        output SI0, SI1, MI0, MI1, tick, at_limit
    );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS BCD up/down stopwatch with a one-second prescaler, clear and preset.
// STOPWATCH_WRAP_EN: when defined, the limit step wraps (59:59 <-> 00:00) instead of halting.
module stopwatch_counter #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    stopwatch_counter_if.slave   bus
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    typedef struct packed {
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    localparam bcd_time_t TIME_MAX = 16'h5959;

    // Increment with ones-to-tens carry; 59:59 rolls naturally to 00:00.
    function automatic bcd_time_t inc_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s0 != 4'd9) begin
            r.s0 = t.s0 + 4'd1;
        end else begin
            r.s0 = 4'd0;
            if (t.s1 != 4'd5) begin
                r.s1 = t.s1 + 4'd1;
            end else begin
                r.s1 = 4'd0;
                if (t.m0 != 4'd9) begin
                    r.m0 = t.m0 + 4'd1;
                end else begin
                    r.m0 = 4'd0;
                    r.m1 = (t.m1 != 4'd5) ? t.m1 + 4'd1 : 4'd0;
                end
            end
        end
        return r;
    endfunction

    // Decrement with borrow; 00:00 rolls naturally to 59:59.
    function automatic bcd_time_t dec_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s0 != 4'd0) begin
            r.s0 = t.s0 - 4'd1;
        end else begin
            r.s0 = 4'd9;
            if (t.s1 != 4'd0) begin
                r.s1 = t.s1 - 4'd1;
            end else begin
                r.s1 = 4'd5;
                if (t.m0 != 4'd0) begin
                    r.m0 = t.m0 - 4'd1;
                end else begin
                    r.m0 = 4'd9;
                    r.m1 = (t.m1 != 4'd0) ? t.m1 - 4'd1 : 4'd5;
                end
            end
        end
        return r;
    endfunction

    // Preset digits outside their BCD range are forced to zero individually.
    function automatic bcd_time_t sanitize(input logic [7:0] mm, input logic [7:0] ss);
        bcd_time_t r;
        r.m1 = (mm[7:4] <= 4'd5) ? mm[7:4] : 4'd0;
        r.m0 = (mm[3:0] <= 4'd9) ? mm[3:0] : 4'd0;
        r.s1 = (ss[7:4] <= 4'd5) ? ss[7:4] : 4'd0;
        r.s0 = (ss[3:0] <= 4'd9) ? ss[3:0] : 4'd0;
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    bcd_time_t        digits_q, digits_d;
    logic             tick_q, tick_d;

    logic             at_limit_c;
    bcd_time_t        step_val_c;

    // Limit flag and candidate next count, both from the registered digits.
    always_comb begin
        at_limit_c = bus.up ? (digits_q == TIME_MAX) : (digits_q == bcd_time_t'(16'h0000));
        step_val_c = bus.up ? inc_time(digits_q) : dec_time(digits_q);
    end

    // Next-state: clr beats load, load beats any step, then the FSM.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        digits_d = digits_q;
        tick_d   = 1'b0;

        if (bus.clr) begin
            state_d  = S_IDLE;
            pre_d    = '0;
            digits_d = '0;
        end else if (bus.load) begin
            state_d  = S_IDLE;
            pre_d    = '0;
            digits_d = sanitize(bus.pmin, bus.psec);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) state_d = S_RUN;
                end
                S_RUN: begin
                    if (!bus.start) begin
                        // Pause keeps the prescaler phase.
                        state_d = S_IDLE;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d = '0;
`ifdef STOPWATCH_WRAP_EN
                        digits_d = step_val_c;
                        tick_d   = 1'b1;
`else
                        if (at_limit_c) begin
                            state_d = S_HALT;
                        end else begin
                            digits_d = step_val_c;
                            tick_d   = 1'b1;
                        end
`endif
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                S_HALT: begin
                    if (!bus.start) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            digits_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            digits_q <= digits_d;
            tick_q   <= tick_d;
        end
    end

    assign bus.SI0      = digits_q.s0;
    assign bus.SI1      = digits_q.s1;
    assign bus.MI0      = digits_q.m0;
    assign bus.MI1      = digits_q.m1;
    assign bus.tick     = tick_q;
    assign bus.at_limit = at_limit_c;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with TICK_DIV=4; limit expectations follow STOPWATCH_WRAP_EN.
module tb_stopwatch_counter;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   n;

    stopwatch_counter_if sw_if ();

    stopwatch_counter #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cur_time();
        return {sw_if.MI1, sw_if.MI0, sw_if.SI1, sw_if.SI0};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Clocks until tick is seen; returns edges taken, or 21 if the bound expires.
    task automatic wait_tick(output int cnt);
        cnt = 21;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (sw_if.tick === 1'b1) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [7:0] mm, input logic [7:0] ss);
        sw_if.pmin = mm;
        sw_if.psec = ss;
        sw_if.load = 1'b1;
        cycle();
        sw_if.load = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        sw_if.start = 1'b0;
        sw_if.up    = 1'b0;
        sw_if.clr   = 1'b0;
        sw_if.load  = 1'b0;
        sw_if.pmin  = 8'h00;
        sw_if.psec  = 8'h00;

        // Reset state
        #12;
        chk("rst_digits", 32'(cur_time()), 32'h0000);
        chk("rst_tick", 32'(sw_if.tick), 32'h0);
        chk("rst_at_limit_down", 32'(sw_if.at_limit), 32'h1);
        sw_if.up = 1'b1;
        #1;
        chk("rst_at_limit_up", 32'(sw_if.at_limit), 32'h0);

        // First tick TICK_DIV clocks after entering RUN
        @(posedge clk);
        #1;
        reset = 1'b1;
        sw_if.start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk("first_tick_early", 32'(sw_if.tick), 32'h0);
        end
        cycle();
        chk("first_tick", 32'(sw_if.tick), 32'h1);
        chk("first_tick_val", 32'(cur_time()), 32'h0001);

        // Asynchronous reset mid-run clears immediately and drops the partial count
        reset = 1'b0;
        #1;
        chk("async_rst_digits", 32'(cur_time()), 32'h0000);
        chk("async_rst_tick", 32'(sw_if.tick), 32'h0);
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        wait_tick(n);
        chk("rst_discard_lat", 32'(n), 32'd5);
        chk("rst_discard_val", 32'(cur_time()), 32'h0001);

        // Up-count carry 00:59 -> 01:00
        sw_if.start = 1'b0;
        cycle();
        do_load(8'h00, 8'h59);
        chk("load_0059", 32'(cur_time()), 32'h0059);
        sw_if.start = 1'b1;
        wait_tick(n);
        chk("carry_lat", 32'(n), 32'd5);
        chk("carry_val", 32'(cur_time()), 32'h0100);

        // Down-count borrow 10:00 -> 09:59
        sw_if.start = 1'b0;
        cycle();
        do_load(8'h10, 8'h00);
        sw_if.up = 1'b0;
        sw_if.start = 1'b1;
        wait_tick(n);
        chk("borrow_lat", 32'(n), 32'd5);
        chk("borrow_val", 32'(cur_time()), 32'h0959);

        // Limit step at 59:59 counting up
        sw_if.start = 1'b0;
        cycle();
        do_load(8'h59, 8'h59);
        sw_if.up = 1'b1;
        #1;
        chk("at_limit_5959_up", 32'(sw_if.at_limit), 32'h1);
        sw_if.start = 1'b1;
`ifdef STOPWATCH_WRAP_EN
        wait_tick(n);
        chk("wrap_up_lat", 32'(n), 32'd5);
        chk("wrap_up_val", 32'(cur_time()), 32'h0000);
        sw_if.up = 1'b0;
        wait_tick(n);
        chk("wrap_down_lat", 32'(n), 32'd4);
        chk("wrap_down_val", 32'(cur_time()), 32'h5959);
`else
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk("sat_no_tick", 32'(sw_if.tick), 32'h0);
        end
        chk("sat_hold", 32'(cur_time()), 32'h5959);
        chk("sat_at_limit", 32'(sw_if.at_limit), 32'h1);
        // HALT ignores direction while start stays high
        sw_if.up = 1'b0;
        wait_tick(n);
        chk("halt_stuck", 32'(n), 32'd21);
        sw_if.start = 1'b0;
        cycle();
        sw_if.start = 1'b1;
        wait_tick(n);
        chk("halt_exit_lat", 32'(n), 32'd5);
        chk("halt_exit_val", 32'(cur_time()), 32'h5958);
        // Down saturation at 00:00
        sw_if.clr = 1'b1;
        cycle();
        sw_if.clr = 1'b0;
        wait_tick(n);
        chk("sat_down_no_tick", 32'(n), 32'd21);
        chk("sat_down_hold", 32'(cur_time()), 32'h0000);
`endif

        // clr and load coincident with a step
        sw_if.start = 1'b0;
        cycle();
        do_load(8'h00, 8'h10);
        sw_if.up = 1'b1;
        sw_if.start = 1'b1;
        for (int i = 1; i <= 4; i++) cycle();
        sw_if.clr  = 1'b1;
        sw_if.load = 1'b1;
        sw_if.pmin = 8'h12;
        sw_if.psec = 8'h34;
        cycle();
        sw_if.clr  = 1'b0;
        sw_if.load = 1'b0;
        chk("clr_step_val", 32'(cur_time()), 32'h0000);
        chk("clr_step_tick", 32'(sw_if.tick), 32'h0);
        wait_tick(n);
        chk("clr_to_idle_lat", 32'(n), 32'd5);

        // load coincident with a step, out-of-range seconds field
        for (int i = 1; i <= 3; i++) cycle();
        do_load(8'h21, 8'h7A);
        chk("load_step_val", 32'(cur_time()), 32'h2100);
        chk("load_step_tick", 32'(sw_if.tick), 32'h0);
        wait_tick(n);
        chk("load_to_idle_lat", 32'(n), 32'd5);
        chk("load_then_up", 32'(cur_time()), 32'h2101);

        // Direction change mid-period keeps prescaler phase
        cycle();
        cycle();
        sw_if.up = 1'b0;
        wait_tick(n);
        chk("dir_change_lat", 32'(n), 32'd2);
        chk("dir_change_val", 32'(cur_time()), 32'h2100);

        // Range sanitising of each field
        sw_if.start = 1'b0;
        cycle();
        do_load(8'h6B, 8'h75);
        chk("sanitize_val", 32'(cur_time()), 32'h0005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
